// File: rtl/alu_pkg.sv
// Shared ALU execute-path definitions: operand width and the sequential-unit
// FSM state encoding used by both the multiplier and the divider.
package alu_pkg;
    localparam int ALU_WIDTH = 32;

    localparam logic [1:0] DIV_IDLE = 2'd0;
    localparam logic [1:0] DIV_RUN  = 2'd1;
    localparam logic [1:0] DIV_DONE = 2'd2;
endpackage

// File: rtl/seq_divider_32b_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial
// subtract the divisor at WIDTH+1 bits, and keep or restore the remainder.
module div_step
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             quo_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_rem,
    output logic             q_bit
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // The extra bit keeps the compare exact when the divisor MSB is set.
    assign shifted  = {rem, quo_msb};
    assign trial    = shifted - {1'b0, divisor};
    assign q_bit    = ~trial[WIDTH];
    assign next_rem = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
endmodule

// File: rtl/seq_divider_32b.sv
// Unsigned restoring divider, one quotient bit per clock, with the same
// start/busy/done handshake as the ALU sequential multiplier.
module seq_divider_32b
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] step_rem;
    logic             step_qbit;
    logic             accept;
    logic             last_iter;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem     (rem_q),
        .quo_msb (quo_q[WIDTH-1]),
        .divisor (dvs_q),
        .next_rem(step_rem),
        .q_bit   (step_qbit)
    );

    assign accept    = (state_q == DIV_IDLE) && start;
    assign last_iter = (state_q == DIV_RUN) && (cnt_q == LAST_CNT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= DIV_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            DIV_IDLE: if (start) state_d = (divisor == '0) ? DIV_DONE : DIV_RUN;
            DIV_RUN:  if (cnt_q == LAST_CNT) state_d = DIV_DONE;
            DIV_DONE: state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != DIV_IDLE);
        done = (state_q == DIV_DONE);
    end

    always_comb begin
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        if (accept) begin
            if (divisor == '0) begin
                // Divide-by-zero skips RUN; results load on the accepting edge.
                quotient_d  = '1;
                remainder_d = dividend;
                dbz_d       = 1'b1;
            end else begin
                dvs_d = divisor;
                rem_d = '0;
                quo_d = dividend;
                cnt_d = '0;
            end
        end else if (state_q == DIV_RUN) begin
            rem_d = step_rem;
            quo_d = {quo_q[WIDTH-2:0], step_qbit};
            cnt_d = cnt_q + 1'b1;
            if (last_iter) begin
                quotient_d  = {quo_q[WIDTH-2:0], step_qbit};
                remainder_d = step_rem;
                dbz_d       = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider_32b.sv
// Directed bench for seq_divider_32b: latency, results, divide-by-zero,
// asynchronous reset mid-operation and start-held handshake.
module tb_seq_divider_32b;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int checks   = 0;
    int failures = 0;

    seq_divider_32b dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
        .remainder  (remainder),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called #1 after a rising edge with start low and the DUT idle.
    task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eq, input logic [31:0] er,
                           input logic edbz, input int elat);
        int lat;
        int bcnt;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = 32'hA5A5_A5A5;
        divisor  = 32'h0000_0001;
        lat  = 0;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (busy) bcnt++;
        end
        chk({name, "_lat"}, lat, elat);
        chk({name, "_busy_cycles"}, bcnt, elat + 1);
        chk({name, "_q"}, quotient, eq);
        chk({name, "_r"}, remainder, er);
        chk({name, "_dbz"}, div_by_zero, edbz);
        @(posedge clk); #1;
        chk({name, "_done_pulse"}, {busy, done}, 2'b00);
    endtask

    initial begin
        int n;
        int seen;
        int changed;

        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {quotient[0 +: 16], remainder[0 +: 14], busy, done}, '0);
        chk("reset_q", quotient, 32'h0);
        chk("reset_dbz", div_by_zero, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_div("d100_7",  32'd100,       32'd7,          32'd14,        32'd2,          1'b0, 32);
        run_div("dmax_1",  32'hFFFF_FFFF, 32'd1,          32'hFFFF_FFFF, 32'h0,          1'b0, 32);
        run_div("d3_10",   32'd3,         32'd10,         32'd0,         32'd3,          1'b0, 32);
        run_div("dmsb_a",  32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         32'h8000_0000,  1'b0, 32);
        run_div("dmsb_b",  32'hFFFF_FFFF, 32'h8000_0000,  32'd1,         32'h7FFF_FFFF,  1'b0, 32);
        run_div("d5_0",    32'd5,         32'd0,          32'hFFFF_FFFF, 32'd5,          1'b1, 0);
        run_div("d9_3",    32'd9,         32'd3,          32'd3,         32'd0,          1'b0, 32);

        // Asynchronous reset in the middle of a division.
        dividend = 32'd1000;
        divisor  = 32'd3;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("areset_q", quotient, 32'h0);
        chk("areset_r", remainder, 32'h0);
        chk("areset_ctl", {busy, done, div_by_zero}, 3'b000);
        #1;
        reset = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1;
        end
        chk("areset_no_done", seen, 0);
        run_div("d1000_3", 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 32);

        // Start held high while operands keep changing.
        dividend = 32'd50;
        divisor  = 32'd7;
        start    = 1'b1;
        @(posedge clk); #1;
        n = 0;
        while (!done && n < 100) begin
            dividend = 32'hDEAD_0000 + n;
            divisor  = n + 2;
            @(posedge clk); #1;
            n++;
        end
        chk("hold1_lat", n, 32);
        chk("hold1_q", quotient, 32'd7);
        chk("hold1_r", remainder, 32'd1);
        @(posedge clk); #1;
        chk("hold_idle_gap", {busy, done}, 2'b00);
        dividend = 32'd200;
        divisor  = 32'd9;
        @(posedge clk); #1;
        chk("hold2_accept", busy, 1'b1);
        n = 0;
        changed = 0;
        while (!done && n < 100) begin
            if (quotient !== 32'd7 || remainder !== 32'd1) changed = 1;
            dividend = 32'hBEEF_0000 + n;
            divisor  = 32'd0;
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        chk("hold_stable", changed, 0);
        chk("hold2_lat", n, 32);
        chk("hold2_q", quotient, 32'd22);
        chk("hold2_r", remainder, 32'd2);
        chk("hold2_dbz", div_by_zero, 1'b0);
        @(posedge clk); #1;
        chk("hold2_end", {busy, done}, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seq_divider_32b.md
Name: seq_divider_32b

Overview:
- Unsigned restoring divider, one quotient bit per clock.
- Inverse companion to the ALU's sequential multiplier. Sits beside it in the ALU execute path.
- Uses the same start/busy/done handshake so the ALU control FSM drives both units identically.
- Produces quotient, remainder and a divide-by-zero flag.

Parameters:
- WIDTH, 32, operand/result width in bits; iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- dividend  input  WIDTH  numerator, captured on accepted start
- divisor  input  WIDTH  denominator, captured on accepted start
- quotient  output  WIDTH  registered result; holds until next result
- remainder  output  WIDTH  registered result; holds until next result
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse when results are valid
- div_by_zero  output  1  registered with results; high iff captured divisor was 0

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high, named reset.
- Reset (any time, including mid-operation):
  - state=IDLE.
  - quotient, remainder, div_by_zero, done, busy = 0.
  - Internal registers and counter cleared.
  - No partial result ever appears.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 with divisor!=0: capture operands, rem_w=0, quo_w=dividend, cnt=0; next state RUN.
  - start=1 with divisor==0: next state DONE; at the same edge load quotient=all ones, remainder=dividend, div_by_zero=1. done is visible in the cycle after the accepting edge.
- RUN, each edge:
  - t = {rem_w[WIDTH-1:0], quo_w[WIDTH-1]} - {1'b0, divisor_r}, computed at WIDTH+1 bits.
  - t[WIDTH]==0: rem_w=t[WIDTH-1:0], quo_w={quo_w[WIDTH-2:0],1}.
  - otherwise: rem_w={rem_w[WIDTH-2:0], quo_w[WIDTH-1]}, quo_w={quo_w[WIDTH-2:0],0}.
  - cnt increments. On the edge where cnt==WIDTH-1, load quotient, remainder and div_by_zero=0 from the final step values, and go to DONE.
- Latency: the accepting edge is E0. WIDTH iterations occur on E1..EWIDTH. done=1 in the cycle after EWIDTH, i.e. 32 clocks after acceptance for WIDTH=32.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- start asserted in RUN or DONE is ignored, not queued. The earliest new acceptance is the cycle after done.
- Operand inputs may change freely after acceptance; only the captured copies are used.
- Arithmetic: unsigned only. The intermediate remainder needs WIDTH+1 bits; this is required for divisors with MSB set.
- Output registers change only on the transition into DONE, and are 0 after reset.

Decomposition:
- Shared package alu_pkg:
  - state encoding constants DIV_IDLE=2'd0, DIV_RUN=2'd1, DIV_DONE=2'd2 (shared with the multiplier FSM style);
  - ALU_WIDTH=32.
- One sub-module, div_step:
  - combinational WIDTH+1-bit trial subtract and restore mux;
  - inputs: rem, quo_msb, divisor;
  - outputs: next_rem, q_bit.
- Top-level holds the FSM, counter and registers.

Test Plan:
- 100 / 7:
  - done exactly 32 clocks after the accepting edge;
  - quotient=14, remainder=2, div_by_zero=0;
  - busy high for 33 cycles.
- 0xFFFFFFFF / 1 -> quotient=0xFFFFFFFF, remainder=0. Then 3 / 10 -> quotient=0, remainder=3.
- 0x80000000 / 0xFFFFFFFF -> quotient=0, remainder=0x80000000. Then 0xFFFFFFFF / 0x80000000 -> quotient=1, remainder=0x7FFFFFFF (exercises the WIDTH+1-bit compare).
- 5 / 0 -> done 1 cycle after acceptance, quotient=0xFFFFFFFF, remainder=5, div_by_zero=1. A following 9 / 3 -> quotient=3, remainder=0, div_by_zero=0.
- Start 1000/3, pulse reset asynchronously (mid-cycle) 10 clocks later:
  - all outputs 0 immediately, state IDLE, no done pulse;
  - a fresh 1000/3 yields quotient=333, remainder=1.
- Handshake:
  - start held high continuously with changing operands: only the first operands are used, and the next acceptance occurs in the cycle after done;
  - the held outputs remain stable between done pulses.
